// File: rtl/mdsa_pkg.sv
// Shared types and helpers for the shearsort matrix sorter.
package mdsa_pkg;

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} mdsa_state_t;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mdsa_row_sorter.sv
// Combinational odd-even transposition sorter for one row of N unsigned keys.
// Depth N guarantees a fully sorted row; equal keys are never swapped.
module mdsa_row_sorter
  import mdsa_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic          dir,
  input  logic [N*DW-1:0] row_in,
  output logic [N*DW-1:0] row_out
);

  logic [DW-1:0] v [N];

  always_comb begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) v[i] = row_in[i*DW +: DW];
    for (int s = 0; s < N; s++) begin
      for (int i = s % 2; i + 1 < N; i += 2) begin
        a = v[i];
        b = v[i+1];
        if ((dir == DIR_ASC) ? (a > b) : (a < b)) begin
          v[i]   = b;
          v[i+1] = a;
        end
      end
    end
    for (int i = 0; i < N; i++) row_out[i*DW +: DW] = v[i];
  end

endmodule

// File: rtl/mdsa_shear_sorter.sv
// Self-sequencing N x N shearsort: 2*log2(N)+1 alternating row/column phases.
// Optional MDSA_ROWMAJOR_OUT_EN: un-snake odd rows on data_out for row-major order.
module mdsa_shear_sorter
  import mdsa_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dir,
  input  logic [N*N*DW-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*DW-1:0] data_out,
  output logic              busy
);

  localparam int L  = clog2(N);
  localparam int PW = clog2(2*L+2);
  localparam int MW = N*N*DW;

  mdsa_state_t     state_reg, state_next;
  logic [PW-1:0]   phase_cnt_reg;
  logic [MW-1:0]   mat_reg;
  logic [MW-1:0]   phase_result;
  logic            dir_reg;
  logic            load;
  logic            is_col;
  logic [N*DW-1:0] sort_in  [N];
  logic [N*DW-1:0] sort_out [N];
  logic [N-1:0]    sort_dir;

  assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign load      = in_valid & in_ready;
  assign busy      = (state_reg == ROW) | (state_reg == COL);
  assign out_valid = (state_reg == DONE);
  assign is_col    = (state_reg == COL);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = ROW;
      ROW:     state_next = (phase_cnt_reg == PW'(2*L)) ? DONE : COL;
      COL:     state_next = ROW;
      DONE:    if (out_ready) state_next = in_valid ? ROW : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mat_reg       <= '0;
      dir_reg       <= DIR_ASC;
      phase_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        mat_reg       <= data_in;
        dir_reg       <= in_dir;
        phase_cnt_reg <= '0;
      end else if (busy) begin
        mat_reg       <= phase_result;
        phase_cnt_reg <= phase_cnt_reg + PW'(1);
      end
    end
  end

  // Column phase feeds sorter r with column r, so one set of row sorters serves both phases.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        sort_in[r][c*DW +: DW] = is_col ? mat_reg[(c*N+r)*DW +: DW]
                                        : mat_reg[(r*N+c)*DW +: DW];
      end
      if (is_col || (r % 2 == 0)) sort_dir[r] = dir_reg;
      else                        sort_dir[r] = (dir_reg == DIR_DESC) ? DIR_ASC : DIR_DESC;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    mdsa_row_sorter #(.N(N), .DW(DW)) u_sorter (
      .dir    (sort_dir[gi]),
      .row_in (sort_in[gi]),
      .row_out(sort_out[gi])
    );
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        phase_result[(r*N+c)*DW +: DW] = is_col ? sort_out[c][r*DW +: DW]
                                                : sort_out[r][c*DW +: DW];
      end
    end
  end

`ifdef MDSA_ROWMAJOR_OUT_EN
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        data_out[(r*N+c)*DW +: DW] = (r % 2 == 1) ? mat_reg[(r*N+N-1-c)*DW +: DW]
                                                  : mat_reg[(r*N+c)*DW +: DW];
      end
    end
  end
`else
  assign data_out = mat_reg;
`endif

endmodule

// File: tb/tb_mdsa_shear_sorter.sv
// Bench for mdsa_shear_sorter: 4x4x8 instance (vectors, random, stall, reset) and default 8x8x32 instance.
module tb_mdsa_shear_sorter;

  localparam int NA = 4, DWA = 8, MA = NA*NA*DWA;
  localparam int NB = 8, DWB = 32, MB = NB*NB*DWB;

  localparam logic [MA-1:0] IN_REV = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [MA-1:0] IN_FWD = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [MA-1:0] ALL_AA = {16{8'haa}};
`ifdef MDSA_ROWMAJOR_OUT_EN
  localparam logic [MA-1:0] EXP_ASC  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [MA-1:0] EXP_DESC = 128'h00010203_04050607_08090a0b_0c0d0e0f;
`else
  localparam logic [MA-1:0] EXP_ASC  = 128'h0c0d0e0f_0b0a0908_04050607_03020100;
  localparam logic [MA-1:0] EXP_DESC = 128'h03020100_04050607_0b0a0908_0c0d0e0f;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid_a, in_ready_a, in_dir_a, out_valid_a, out_ready_a, busy_a;
  logic [MA-1:0] data_in_a, data_out_a;
  logic          in_valid_b, in_ready_b, in_dir_b, out_valid_b, out_ready_b, busy_b;
  logic [MB-1:0] data_in_b, data_out_b;

  int tests = 0;
  int fails = 0;

  mdsa_shear_sorter #(.N(NA), .DW(DWA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_dir(in_dir_a),
    .data_in(data_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .data_out(data_out_a), .busy(busy_a)
  );

  mdsa_shear_sorter dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_dir(in_dir_b),
    .data_in(data_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .data_out(data_out_b), .busy(busy_b)
  );

  // Shearsort of a power-of-two matrix ends fully sorted in snake order.
  function automatic logic [MB-1:0] ref_model(input int n, input int dw, input logic d,
                                               input logic [MB-1:0] m);
    longint q[$];
    longint mask;
    logic [MB-1:0] res;
    int src;
    mask = (longint'(1) << dw) - 1;
    for (int i = 0; i < n*n; i++) q.push_back(longint'(m >> (i*dw)) & mask);
    if (d) q.rsort();
    else   q.sort();
    res = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        src = r*n + c;
`ifndef MDSA_ROWMAJOR_OUT_EN
        if (r % 2 == 1) src = r*n + (n-1-c);
`endif
        res = res | (MB'(q[src] & mask) << ((r*n+c)*dw));
      end
    end
    return res;
  endfunction

  task automatic chk_v(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    tests++;
    if (act !== exp) begin
      int w = 0;
      fails++;
      for (int i = MB/32-1; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      $display("FAIL %s: word %0d got %h, required %h", name, w, act[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic accept_a(input logic d, input logic [MA-1:0] m);
    int k = 0;
    @(negedge clk);
    in_valid_a = 1'b1; in_dir_a = d; data_in_a = m;
    #1;
    while (!in_ready_a && k < 40) begin @(negedge clk); #1; k++; end
    if (!in_ready_a) begin fails++; tests++; $display("FAIL accept_a: in_ready got 0, required 1"); end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic wait_out_a(output int lat);
    lat = 0;
    while (!out_valid_a && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid_a) begin fails++; tests++; $display("FAIL wait_a: out_valid got 0, required 1"); end
  endtask

  task automatic drain_a();
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
  endtask

  task automatic run_a(input logic d, input logic [MA-1:0] m, output logic [MA-1:0] res,
                       output int lat);
    accept_a(d, m);
    wait_out_a(lat);
    res = data_out_a;
    drain_a();
  endtask

  task automatic run_b(input logic d, input logic [MB-1:0] m, output logic [MB-1:0] res,
                       output int lat);
    int k = 0;
    @(negedge clk);
    in_valid_b = 1'b1; in_dir_b = d; data_in_b = m;
    #1;
    while (!in_ready_b && k < 40) begin @(negedge clk); #1; k++; end
    if (!in_ready_b) begin fails++; tests++; $display("FAIL accept_b: in_ready got 0, required 1"); end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid_b) begin fails++; tests++; $display("FAIL wait_b: out_valid got 0, required 1"); end
    res = data_out_b;
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
  endtask

  typedef struct {
    logic          dir;
    logic [MA-1:0] din;
    logic [MA-1:0] dout;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [MA-1:0] res_a, m_a, m2_a, exp_a;
    logic [MB-1:0] res_b, m_b;
    logic d;
    int lat;

    vecs[0].dir = 1'b0; vecs[0].din = IN_REV; vecs[0].dout = EXP_ASC;
    vecs[1].dir = 1'b1; vecs[1].din = IN_REV; vecs[1].dout = EXP_DESC;
    vecs[2].dir = 1'b0; vecs[2].din = ALL_AA; vecs[2].dout = ALL_AA;
    vecs[3].dir = 1'b1; vecs[3].din = ALL_AA; vecs[3].dout = ALL_AA;
    vecs[4].dir = 1'b0; vecs[4].din = IN_FWD; vecs[4].dout = EXP_ASC;

    rst = 1'b1;
    in_valid_a = 1'b0; in_dir_a = 1'b0; data_in_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_dir_b = 1'b0; data_in_b = '0; out_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_i("reset_in_ready", int'(in_ready_a), 1);
    chk_i("reset_out_valid", int'(out_valid_a), 0);
    chk_i("reset_busy", int'(busy_a), 0);
    chk_v("reset_data_out", data_out_a, '0);
    chk_i("reset_out_valid_b", int'(out_valid_b), 0);
    chk_v("reset_data_out_b", data_out_b, '0);
    $display("[TB] reset checked");

    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i].dir, vecs[i].din, res_a, lat);
      chk_v($sformatf("vec%0d_data", i), res_a, vecs[i].dout);
      chk_i($sformatf("vec%0d_latency", i), lat, 5);
      $display("[TB] vec %0d dir=%0b in=%h out=%h lat=%0d", i, vecs[i].dir, vecs[i].din, res_a, lat);
    end

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NA*NA; i++)
        m_a[i*8 +: 8] = (n % 2 == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      run_a(d, m_a, res_a, lat);
      chk_v("rand_a_data", res_a, ref_model(NA, DWA, d, m_a));
      $display("[TB] rand_a %0d dir=%0b in=%h out=%h", n, d, m_a, res_a);
    end

    // Output backpressure, then reload on the same edge that releases the result.
    for (int i = 0; i < NA*NA; i++) m_a[i*8 +: 8] = 8'($urandom_range(0, 15));
    for (int i = 0; i < NA*NA; i++) m2_a[i*8 +: 8] = 8'($urandom_range(0, 255));
    accept_a(1'b0, m_a);
    wait_out_a(lat);
    exp_a = MA'(ref_model(NA, DWA, 1'b0, m_a));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_i("stall_out_valid", int'(out_valid_a), 1);
      chk_i("stall_in_ready", int'(in_ready_a), 0);
      chk_v("stall_data", data_out_a, exp_a);
    end
    $display("[TB] stall held 10 cycles out=%h", data_out_a);
    @(negedge clk);
    out_ready_a = 1'b1; in_valid_a = 1'b1; in_dir_a = 1'b1; data_in_a = m2_a;
    #1;
    chk_i("reload_in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;
    out_ready_a = 1'b0; in_valid_a = 1'b0;
    chk_i("reload_busy", int'(busy_a), 1);
    chk_i("reload_out_valid", int'(out_valid_a), 0);
    wait_out_a(lat);
    chk_i("reload_latency", lat, 5);
    chk_v("reload_data", data_out_a, ref_model(NA, DWA, 1'b1, m2_a));
    $display("[TB] reload in=%h out=%h lat=%0d", m2_a, data_out_a, lat);
    drain_a();

    // Abort mid-sort while phase_cnt is 2.
    accept_a(1'b0, IN_REV);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_i("abort_out_valid", int'(out_valid_a), 0);
    chk_i("abort_in_ready", int'(in_ready_a), 1);
    chk_i("abort_busy", int'(busy_a), 0);
    chk_v("abort_data_out", data_out_a, '0);
    rst = 1'b0;
    $display("[TB] abort checked");
    for (int i = 0; i < NA*NA; i++) m_a[i*8 +: 8] = 8'($urandom_range(0, 255));
    run_a(1'b1, m_a, res_a, lat);
    chk_v("post_abort_data", res_a, ref_model(NA, DWA, 1'b1, m_a));
    chk_i("post_abort_latency", lat, 5);
    $display("[TB] post_abort in=%h out=%h", m_a, res_a);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NB*NB; i++)
        m_b[i*32 +: 32] = (n % 2 == 1) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      d = 1'($urandom_range(0, 1));
      run_b(d, m_b, res_b, lat);
      chk_v("rand_b_data", res_b, ref_model(NB, DWB, d, m_b));
      chk_i("rand_b_latency", lat, 7);
      $display("[TB] rand_b %0d dir=%0b lat=%0d first=%h last=%h", n, d, lat,
               res_b[31:0], res_b[MB-1 -: 32]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdsa_shear_sorter.md
# mdsa_shear_sorter

Parametrised N×N multidimensional sorter that runs a complete shearsort on its own. One matrix enters through a valid/ready handshake. The block then alternates row phases and column phases on an internal matrix register under an FSM. The sorted matrix leaves through a second valid/ready handshake. It replaces the externally sequenced row-sorter/transpose feedback loop: callers no longer drive `trans`, `start` or per-row direction.

## Interface
- `N`, 8: matrix dimension; power of two, ≥2
- `DW`, 32: element width, unsigned compare
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `in_valid` in 1: input matrix valid
- `in_ready` out 1: block can accept a matrix
- `in_dir` in 1: sort order, 0 = ascending, 1 = descending; sampled with the matrix
- `data_in` in N\*N\*DW: element (r,c) at bits [(r\*N+c)\*DW +: DW]
- `out_valid` out 1: sorted matrix valid
- `out_ready` in 1: consumer accepts
- `data_out` out N\*N\*DW: sorted matrix, same packing as `data_in`
- `busy` out 1: high in ROW/COL states

## Operation
- L = log2(N). Total phases = 2L+1, counted by `phase_cnt`, 0..2L.
- Even `phase_cnt` is a row phase:
  - even-indexed rows sort in direction `dir`;
  - odd-indexed rows sort in direction `~dir` (snake order).
- Odd `phase_cnt` is a column phase: every column sorts in direction `dir`, with row 0 as the smallest index.
  - Implemented as transpose, then all rows sort in `dir`, then transpose back, all within one cycle.
- Every phase uses the same N row-sorter instances; an input mux selects between the matrix and its transpose.
- FSM states:
  - **IDLE**: `in_ready`=1. On `in_valid`: load the matrix, latch `dir`, set `phase_cnt`=0, go to ROW.
  - **ROW**: perform a row phase, increment `phase_cnt`. Go to COL, or to DONE if `phase_cnt`==2L.
  - **COL**: perform a column phase, increment `phase_cnt`, go to ROW.
  - **DONE**: `out_valid`=1 and `data_out` is the matrix register. On `out_ready`:
    - with `in_valid`: load the new matrix and go to ROW;
    - without `in_valid`: go to IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). This is a combinational path from `out_ready`.
- Equal keys: compare-exchange swaps only on strict inequality; duplicates are preserved.
- Input is ignored while in ROW or COL, because `in_ready`=0.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `data_out` all zeros (matrix register cleared);
  - `phase_cnt`=0.
- Reset in any state aborts the current matrix and takes effect at the next edge. No partial result is emitted.
- Latency: `out_valid` rises 2L+1 edges after the accepting edge. This is 7 for N=8 and 5 for N=4.
- Throughput: one matrix per 2L+2 cycles with back-to-back DONE→ROW reload.
- `data_out` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- Each phase is a single-cycle combinational odd-even transposition network of depth N plus a transpose.

## Configuration
- `MDSA_ROWMAJOR_OUT_EN` defined: the `data_out` path reverses odd rows, so the output is fully sorted in row-major order in direction `dir`. The reversal is combinational; latency is unchanged.
- Not defined: `data_out` is the raw snake order, with odd rows reversed relative to even rows.

## Structure
- Package `mdsa_pkg` holds:
  - state enum `mdsa_state_t` {IDLE, ROW, COL, DONE};
  - constants `DIR_ASC`=0 and `DIR_DESC`=1;
  - a `clog2` helper function.
- Sub-module `mdsa_row_sorter` (parameters N, DW; ports `dir`, `row_in`, `row_out`): combinational odd-even transposition network. It is instantiated N times in the top.
- Top contains the FSM, `phase_cnt`, matrix register, transpose wiring, phase mux and output reorder.

## Test plan
- N=4, DW=8, `in_dir`=0, element (r,c)=15−(4r+c):
  - macro off → rows {0,1,2,3},{7,6,5,4},{8,9,10,11},{15,14,13,12};
  - macro on → 0..15 row-major;
  - `out_valid` on the 5th edge after accept.
- Same input with `in_dir`=1, macro on → 15..0 row-major.
- All elements 0xAA → output identical to input; random matrices with duplicates match the reference model, 1000 runs.
- `out_ready` held low for 10 cycles in DONE → `data_out` and `out_valid` stable, `in_ready`=0; releasing `out_ready` with `in_valid` high → new matrix accepted on the same edge, `busy`=1 on the next cycle.
- Assert `rst` during `phase_cnt`=2 → next cycle `out_valid`=0, `in_ready`=1, `data_out`=0, `busy`=0; a following matrix sorts correctly.
- N=8, DW=32 default instance, random matrix → sorted, `out_valid` 7 edges after accept.
